// File: rtl/bus_xfer_unit.sv
// bus_xfer_unit: common-bus transfer engine moving one register or memory source onto the bus
// and into any set of destination registers and/or memory. Optional load op: `define BUS_XFER_OP_EN.
module bus_xfer_unit #(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int NREG    = 6,
  parameter int MEM_LAT = 1,
  parameter int SW      = $clog2(NREG + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SW-1:0]      cmd_src,
  input  logic [NREG-1:0]    cmd_dst,
  input  logic               cmd_memwr,
  input  logic [AW-1:0]      cmd_addr,
`ifdef BUS_XFER_OP_EN
  input  logic [1:0]         cmd_op,
`endif
  output logic [AW-1:0]      mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic [DW-1:0]      bus,
  output logic [NREG*DW-1:0] regs,
  output logic               done,
  output logic               err
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // RD    | memory read strobe issued at captured address
  // WAIT  | counting down remaining memory read latency
  // EXEC  | source on bus, destinations load at end of cycle
  typedef enum logic [1:0] {IDLE, RD, WAIT, EXEC} state_t;

  localparam logic [SW-1:0] SRC_MEM   = SW'(NREG);
  localparam logic [2:0]    WAIT_LOAD = 3'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  state_t          state_q, state_d;
  logic [SW-1:0]   src_q;
  logic [NREG-1:0] dst_q;
  logic            memwr_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      cnt_q;
  logic            err_q;
  logic [DW-1:0]   reg_q [NREG];
  logic            accept;
  logic            reject;
  logic [DW-1:0]   src_val;
  logic [DW-1:0]   load_val;
`ifdef BUS_XFER_OP_EN
  logic [1:0]      op_q;
`endif

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign err       = err_q && !rst;

  always_comb begin
    reject = (cmd_src > SRC_MEM) || ((cmd_src == SRC_MEM) && cmd_memwr);
`ifdef BUS_XFER_OP_EN
    if (cmd_op == 2'b11) reject = 1'b1;
`endif
  end

  // Rejected commands never reach EXEC, so src_q is always a register or the memory port here.
  always_comb begin
    src_val = mem_rdata;
    for (int i = 0; i < NREG; i++) begin
      if (src_q == SW'(i)) src_val = reg_q[i];
    end
  end

  always_comb begin
    load_val = src_val;
`ifdef BUS_XFER_OP_EN
    case (op_q)
      2'b01:   load_val = src_val + DW'(1);
      2'b10:   load_val = '0;
      default: load_val = src_val;
    endcase
`endif
  end

  always_comb begin
    state_d   = state_q;
    bus       = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    mem_addr  = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !reject) state_d = (cmd_src == SRC_MEM) ? RD : EXEC;
      end
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        state_d  = (MEM_LAT == 1) ? EXEC : WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = EXEC;
      end
      EXEC: begin
        bus       = src_val;
        done      = 1'b1;
        mem_wr    = memwr_q;
        mem_wdata = src_val;
        mem_addr  = addr_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts in the same cycle: no strobes, no done.
    if (rst) begin
      state_d   = IDLE;
      bus       = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wdata = '0;
      mem_addr  = '0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      memwr_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef BUS_XFER_OP_EN
      op_q    <= 2'b00;
`endif
      for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && reject;
      if (accept) begin
        src_q   <= cmd_src;
        dst_q   <= cmd_dst;
        memwr_q <= cmd_memwr;
        addr_q  <= cmd_addr;
`ifdef BUS_XFER_OP_EN
        op_q    <= cmd_op;
`endif
      end
      if (state_q == RD) cnt_q <= WAIT_LOAD;
      else if ((state_q == WAIT) && (cnt_q != 3'd0)) cnt_q <= cnt_q - 3'd1;
      if (state_q == EXEC) begin
        for (int i = 0; i < NREG; i++) begin
          if (dst_q[i]) reg_q[i] <= load_val;
        end
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign regs[g*DW +: DW] = reg_q[g];
  end

endmodule

// File: tb/tb_bus_xfer_unit.sv
// Directed self-checking bench for bus_xfer_unit with NREG=6, MEM_LAT=3 and a latency-modelled memory.
module tb_bus_xfer_unit;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NREG = 6;
  localparam int MEM_LAT = 3;
  localparam int SW = 3;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [SW-1:0]     cmd_src;
  logic [NREG-1:0]   cmd_dst;
  logic              cmd_memwr;
  logic [AW-1:0]     cmd_addr;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic [DW-1:0]     bus;
  logic [NREG*DW-1:0] regs;
  logic              done;
  logic              err;

  int n_assert = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rd_before;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [MEM_LAT-1:0] pv;
  logic [AW-1:0]      pa0, pa1, pa2;

  bus_xfer_unit #(.DW(DW), .AW(AW), .NREG(NREG), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_memwr(cmd_memwr), .cmd_addr(cmd_addr),
`ifdef BUS_XFER_OP_EN
    .cmd_op(cmd_op),
`endif
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .bus(bus), .regs(regs), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    case (a)
      8'h01:   return 16'hBEEF;
      8'h10:   return 16'h1234;
      8'h11:   return 16'hFFFF;
      default: return {8'hA5, a};
    endcase
  endfunction

  // Read data appears MEM_LAT cycles after the strobe and is garbage otherwise.
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[MEM_LAT-2:0], mem_rd};
    pa0 <= mem_addr;
    pa1 <= pa0;
    pa2 <= pa1;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end
  assign mem_rdata = pv[MEM_LAT-1] ? memf(pa2) : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [SW-1:0] src, input logic [NREG-1:0] dst, input logic memwr,
                       input logic [AW-1:0] addr, input logic [1:0] op);
    chk("ready_before_issue", {127'b0, cmd_ready}, 128'd1);
    cmd_valid = 1'b1;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_memwr = memwr;
    cmd_addr  = addr;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    cmd_src   = 3'd5;
    cmd_dst   = 6'h3f;
    cmd_memwr = 1'b1;
    cmd_addr  = 8'h55;
    cmd_op    = 2'b01;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_memwr = 1'b0;
    cmd_addr = '0;
    cmd_op = 2'b00;
    tick(); tick(); tick();
    chk("ready_in_rst", {127'b0, cmd_ready}, 128'd0);
    chk("done_in_rst", {127'b0, done}, 128'd0);
    chk("regs_in_rst", {32'b0, regs}, 128'd0);

    rst = 1'b0;
    tick();
    chk("ready_after_rst", {127'b0, cmd_ready}, 128'd1);
    chk("bus_after_rst", {112'b0, bus}, 128'd0);
    chk("done_after_rst", {127'b0, done}, 128'd0);
    chk("err_after_rst", {127'b0, err}, 128'd0);
    chk("memrd_after_rst", {127'b0, mem_rd}, 128'd0);

    // Memory read mem[0x01] into reg1.
    issue(3'd6, 6'b000010, 1'b0, 8'h01, 2'b00);
    chk("t1_memrd_k1", {127'b0, mem_rd}, 128'd1);
    chk("t1_addr_k1", {120'b0, mem_addr}, 128'h01);
    chk("t1_ready_k1", {127'b0, cmd_ready}, 128'd0);
    chk("t1_done_k1", {127'b0, done}, 128'd0);
    tick();
    chk("t1_memrd_k2", {127'b0, mem_rd}, 128'd0);
    chk("t1_done_k2", {127'b0, done}, 128'd0);
    chk("t1_addr_k2", {120'b0, mem_addr}, 128'd0);
    tick();
    chk("t1_done_k3", {127'b0, done}, 128'd0);
    tick();
    chk("t1_done_k4", {127'b0, done}, 128'd1);
    chk("t1_bus_k4", {112'b0, bus}, 128'hBEEF);
    chk("t1_memwr_k4", {127'b0, mem_wr}, 128'd0);
    tick();
    chk("t1_regs", {32'b0, regs}, 128'h0000_0000_0000_0000_BEEF_0000);
    chk("t1_done_k5", {127'b0, done}, 128'd0);

    // reg1 to reg0, reg5 and memory 0x20.
    issue(3'd1, 6'b100001, 1'b1, 8'h20, 2'b00);
    chk("t2_done", {127'b0, done}, 128'd1);
    chk("t2_memwr", {127'b0, mem_wr}, 128'd1);
    chk("t2_wdata", {112'b0, mem_wdata}, 128'hBEEF);
    chk("t2_addr", {120'b0, mem_addr}, 128'h20);
    chk("t2_bus", {112'b0, bus}, 128'hBEEF);
    chk("t2_ready_exec", {127'b0, cmd_ready}, 128'd0);
    tick();
    chk("t2_regs", {32'b0, regs}, 128'hBEEF_0000_0000_0000_BEEF_BEEF);
    chk("t2_wrcnt", 128'(wr_cnt), 128'd1);
    chk("t2_wraddr", {120'b0, wr_addr}, 128'h20);
    chk("t2_wrdata", {112'b0, wr_data}, 128'hBEEF);

    // Source also in destination mask reloads itself.
    issue(3'd0, 6'b000101, 1'b0, 8'h33, 2'b00);
    chk("t3_done", {127'b0, done}, 128'd1);
    chk("t3_memwr", {127'b0, mem_wr}, 128'd0);
    chk("t3_addr", {120'b0, mem_addr}, 128'h33);
    tick();
    chk("t3_regs", {32'b0, regs}, 128'hBEEF_0000_0000_BEEF_BEEF_BEEF);

    // Empty command: done but no state change.
    issue(3'd2, 6'b000000, 1'b0, 8'h00, 2'b00);
    chk("t4_done", {127'b0, done}, 128'd1);
    chk("t4_bus", {112'b0, bus}, 128'hBEEF);
    tick();
    chk("t4_regs", {32'b0, regs}, 128'hBEEF_0000_0000_BEEF_BEEF_BEEF);
    chk("t4_wrcnt", 128'(wr_cnt), 128'd1);

    // Source out of range.
    issue(3'd7, 6'b111111, 1'b0, 8'h00, 2'b00);
    chk("t5_err", {127'b0, err}, 128'd1);
    chk("t5_done", {127'b0, done}, 128'd0);
    chk("t5_ready", {127'b0, cmd_ready}, 128'd1);
    tick();
    chk("t5_err_clear", {127'b0, err}, 128'd0);
    chk("t5_regs", {32'b0, regs}, 128'hBEEF_0000_0000_BEEF_BEEF_BEEF);

    // Memory-to-memory rejected.
    rd_before = rd_cnt;
    issue(3'd6, 6'b000001, 1'b1, 8'h01, 2'b00);
    chk("t6_err", {127'b0, err}, 128'd1);
    chk("t6_memrd", {127'b0, mem_rd}, 128'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_rdcnt", 128'(rd_cnt), 128'(rd_before));
    chk("t6_wrcnt", 128'(wr_cnt), 128'd1);
    chk("t6_regs", {32'b0, regs}, 128'hBEEF_0000_0000_BEEF_BEEF_BEEF);

    // Reset during WAIT of a memory read.
    issue(3'd6, 6'b001000, 1'b0, 8'h10, 2'b00);
    tick();
    rst = 1'b1;
    chk("t7_done_rst", {127'b0, done}, 128'd0);
    tick();
    chk("t7_done_in_rst", {127'b0, done}, 128'd0);
    chk("t7_ready_in_rst", {127'b0, cmd_ready}, 128'd0);
    chk("t7_regs_rst", {32'b0, regs}, 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7_no_done", {127'b0, done}, 128'd0);
    end
    chk("t7_regs_after", {32'b0, regs}, 128'd0);
    chk("t7_ready_after", {127'b0, cmd_ready}, 128'd1);

    // Fresh memory read after abort: mem[0x11] into reg2.
    issue(3'd6, 6'b000100, 1'b0, 8'h11, 2'b00);
    tick(); tick();
    chk("t8_done_k3", {127'b0, done}, 128'd0);
    tick();
    chk("t8_done_k4", {127'b0, done}, 128'd1);
    chk("t8_bus", {112'b0, bus}, 128'hFFFF);
    tick();
    chk("t8_regs", {32'b0, regs}, 128'h0000_0000_0000_FFFF_0000_0000);

`ifdef BUS_XFER_OP_EN
    issue(3'd2, 6'b000100, 1'b0, 8'h00, 2'b01);
    chk("op_inc_bus", {112'b0, bus}, 128'hFFFF);
    tick();
    chk("op_inc_wrap", {112'b0, regs[47:32]}, 128'h0000);
    issue(3'd6, 6'b000100, 1'b0, 8'h01, 2'b00);
    tick(); tick(); tick(); tick();
    chk("op_reload", {112'b0, regs[47:32]}, 128'hBEEF);
    issue(3'd2, 6'b000100, 1'b1, 8'h40, 2'b10);
    chk("op_clr_wdata", {112'b0, mem_wdata}, 128'hBEEF);
    tick();
    chk("op_clr_reg", {112'b0, regs[47:32]}, 128'h0000);
    issue(3'd1, 6'b000001, 1'b0, 8'h00, 2'b11);
    chk("op_11_err", {127'b0, err}, 128'd1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
